// File: rtl/axi_lite_timer_slave.sv
// AXI4-Lite slave exposing CTRL / LOAD / COUNT / STATUS registers around a
// down-counting timer with a level interrupt on expiry.
// Optional build macro: AXI_TIMER_PRESCALE_EN adds a 16-bit PRESCALE register
// at offset 0x10 that divides the timer tick by PRESCALE+1.
module axi_lite_timer_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              irq
);

  // Word offsets decoded from address bits [4:2]
  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_LOAD     = 3'd1;
  localparam logic [2:0] A_COUNT    = 3'd2;
  localparam logic [2:0] A_STATUS   = 3'd3;
`ifdef AXI_TIMER_PRESCALE_EN
  localparam logic [2:0] A_PRESCALE = 3'd4;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  genvar gi;

  // AXI channel state
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_aw_done;
  logic        r_w_done;
  logic [2:0]  r_wr_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  // Register file and timer state
  logic [2:0]  r_ctrl;      // {irq_en, auto_reload, en}
  logic [31:0] r_load;
  logic [31:0] r_count;
  logic        r_expired;
  logic        r_irq;
  state_t      r_state;

  // Handshakes and decoded write strobes
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_b_hs;
  logic        w_r_hs;
  logic        w_wr_fire;
  logic        w_wr_ctrl;
  logic        w_wr_load;
  logic        w_wr_status;
  logic [2:0]  w_ctrl_wdata;
  logic [31:0] w_load_merged;
  logic [31:0] w_rd_mux;
  logic        w_tick;

  // Timer next-state outputs
  state_t      w_state_next;
  logic [31:0] w_count_next;
  logic        w_set_expired;
  logic        w_hw_stop;
  logic        w_start;

  // Protection bits and the byte-offset address bits carry no meaning here
  logic        w_unused;
  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign w_aw_hs   = r_awready & s00_axi_awvalid;
  assign w_w_hs    = r_wready  & s00_axi_wvalid;
  assign w_ar_hs   = r_arready & s00_axi_arvalid;
  assign w_b_hs    = r_bvalid  & s00_axi_bready;
  assign w_r_hs    = r_rvalid  & s00_axi_rready;
  // Commit once both halves are captured; bvalid blocks a second commit
  assign w_wr_fire = r_aw_done & r_w_done & ~r_bvalid;

  assign w_wr_ctrl   = w_wr_fire & (r_wr_idx == A_CTRL);
  assign w_wr_load   = w_wr_fire & (r_wr_idx == A_LOAD);
  assign w_wr_status = w_wr_fire & (r_wr_idx == A_STATUS);

  // CTRL only has three implemented bits, all in byte lane 0
  assign w_ctrl_wdata = r_wstrb[0] ? r_wdata[2:0] : r_ctrl;

  // LOAD honours each byte enable independently
  generate
    for (gi = 0; gi < 4; gi++) begin : g_load_lane
      assign w_load_merged[8*gi +: 8] = r_wstrb[gi] ? r_wdata[8*gi +: 8]
                                                    : r_load[8*gi +: 8];
    end
  endgenerate

`ifdef AXI_TIMER_PRESCALE_EN
  logic [15:0] r_prescale;
  logic [15:0] r_psc_cnt;
  logic        w_wr_prescale;
  logic [15:0] w_prescale_merged;

  assign w_wr_prescale = w_wr_fire & (r_wr_idx == A_PRESCALE);

  generate
    for (gi = 0; gi < 2; gi++) begin : g_psc_lane
      assign w_prescale_merged[8*gi +: 8] = r_wstrb[gi] ? r_wdata[8*gi +: 8]
                                                        : r_prescale[8*gi +: 8];
    end
  endgenerate

  // >= rather than == so lowering PRESCALE mid-count never waits for a wrap
  assign w_tick = (r_psc_cnt >= r_prescale);

  // Prescaler register and divider; the divider restarts on every timer start
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      r_prescale <= '0;
      r_psc_cnt  <= '0;
    end else begin
      if (w_wr_prescale) r_prescale <= w_prescale_merged;
      if (w_start || w_tick) r_psc_cnt <= '0;
      else                   r_psc_cnt <= r_psc_cnt + 16'd1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Write channel: independent AW/W capture, single outstanding write
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_wr_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_awready <= ~r_awready & ~r_aw_done & s00_axi_awvalid;
      r_wready  <= ~r_wready  & ~r_w_done  & s00_axi_wvalid;
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
        r_wr_idx  <= s00_axi_awaddr[4:2];
      end
      if (w_w_hs) begin
        r_w_done <= 1'b1;
        r_wdata  <= s00_axi_wdata[31:0];
        r_wstrb  <= s00_axi_wstrb[3:0];
      end
      if (w_wr_fire) r_bvalid <= 1'b1;
      if (w_b_hs) begin
        r_bvalid  <= 1'b0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
    end
  end

  // Read data decode from the current (pre-write) register contents
  always_comb begin
    w_rd_mux = '0;
    case (s00_axi_araddr[4:2])
      A_CTRL:     w_rd_mux = {29'd0, r_ctrl};
      A_LOAD:     w_rd_mux = r_load;
      A_COUNT:    w_rd_mux = r_count;
      A_STATUS:   w_rd_mux = {31'd0, r_expired};
`ifdef AXI_TIMER_PRESCALE_EN
      A_PRESCALE: w_rd_mux = {16'd0, r_prescale};
`endif
      default:    w_rd_mux = '0;
    endcase
  end

  // Read channel: arready pulse, registered data held until rready
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= ~r_arready & ~r_rvalid & s00_axi_arvalid;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Timer next-state: start on en rising, count down, expire, reload or stop
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_set_expired = 1'b0;
    w_hw_stop     = 1'b0;
    w_start       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_ctrl && w_ctrl_wdata[0] && !r_ctrl[0]) begin
          w_start      = 1'b1;
          w_state_next = ST_RUN;
          w_count_next = r_load;
        end
      end
      ST_RUN: begin
        if (w_wr_ctrl && !w_ctrl_wdata[0]) begin
          w_state_next = ST_IDLE;
        end else if (w_tick) begin
          if (r_count != 32'd0) begin
            w_count_next = r_count - 32'd1;
          end else begin
            w_set_expired = 1'b1;
            if (r_ctrl[1]) begin
              w_count_next = r_load;
            end else begin
              w_hw_stop    = 1'b1;
              w_state_next = ST_IDLE;
            end
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Timer state, register file updates and interrupt
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= '0;
      r_load    <= '0;
      r_count   <= '0;
      r_expired <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_wr_ctrl) r_ctrl <= w_ctrl_wdata;
      // A one-shot expiry clears en even if software rewrote CTRL this cycle,
      // keeping en and the IDLE state in agreement
      if (w_hw_stop) r_ctrl[0] <= 1'b0;
      if (w_wr_load) r_load <= w_load_merged;
      // Hardware set beats a simultaneous write-1-to-clear
      if (w_set_expired) begin
        r_expired <= 1'b1;
      end else if (w_wr_status && r_wstrb[0] && r_wdata[0]) begin
        r_expired <= 1'b0;
      end
      r_irq <= r_expired & r_ctrl[2];
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_wready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign irq             = r_irq;

endmodule

// File: tb/tb_axi_lite_timer_slave.sv
// Self-checking bench for axi_lite_timer_slave: register-map vector table,
// hand-written timing sequences and randomized timer runs against a
// closed-form model of the countdown.
`timescale 1ns/1ps
module tb_axi_lite_timer_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        irq;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_timer_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_reset   (rst),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .irq             (irq)
  );

`ifdef AXI_TIMER_PRESCALE_EN
  localparam logic [31:0] EXP_PSC = 32'h0000_2345;
`else
  localparam logic [31:0] EXP_PSC = 32'h0;
`endif

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count value after k ticks from the start edge
  function automatic int mdl_count(input int k, input int l, input bit ar);
    if (ar) return l - (k % (l + 1));
    return (k <= l) ? (l - k) : 0;
  endfunction

  function automatic bit mdl_expired(input int k, input int l);
    return k >= l + 1;
  endfunction

  function automatic bit mdl_en(input int k, input int l, input bit ar);
    return ar ? 1'b1 : (k <= l);
  endfunction

  // Full write with optional W lag, B backpressure and AW held after its
  // handshake; upd returns the edge on which bvalid (and the register) changed
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_delay,
                           input int b_delay, input bit hold_aw, output int upd);
    bit aw_done, w_done, b_done, seen_b, hs_aw, hs_w, hs_b;
    int n, viol;
    logic [1:0] resp;
    aw_done = 0; w_done = 0; b_done = 0; seen_b = 0; n = 0; viol = 0; upd = -1;
    resp = 2'b11;
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb;
    wvalid = (w_delay == 0); bready = 1'b0;
    while (!b_done && n < 60) begin
      if (aw_done && awready) viol++;
      if (w_done && wready) viol++;
      if (seen_b && !bvalid) viol++;
      if (bvalid && !seen_b) begin
        seen_b = 1; upd = cyc;
        if (!(aw_done && w_done)) viol++;
      end
      if (seen_b) bready = ((cyc - upd) >= b_delay);
      hs_aw = awvalid && awready && !aw_done;
      hs_w  = wvalid && wready && !w_done;
      hs_b  = bvalid && bready;
      if (hs_b) resp = bresp;
      tick();
      n++;
      if (hs_aw) begin
        aw_done = 1;
        if (hold_aw) awaddr = 5'h1C;
        else awvalid = 1'b0;
      end
      if (hs_w) begin w_done = 1; wvalid = 1'b0; end
      if (hs_b) begin b_done = 1; bready = 1'b0; end
      if (!w_done && !wvalid && n >= w_delay) wvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    check($sformatf("wr_done@%02h", addr), b_done, 1'b1);
    check($sformatf("wr_proto@%02h", addr), viol, 0);
    if (b_done) check($sformatf("bresp@%02h", addr), resp, 2'b00);
  endtask

  // Full read; smp is the edge whose resulting state the data reflects
  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output int smp);
    bit ar_done, r_done, hs_ar, hs_r;
    int n;
    logic [1:0] resp;
    ar_done = 0; r_done = 0; n = 0; smp = -1; data = '0; resp = 2'b11;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!r_done && n < 60) begin
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready && ar_done;
      if (hs_ar) smp = cyc;
      if (hs_r) begin data = rdata; resp = rresp; end
      tick();
      n++;
      if (hs_ar) begin ar_done = 1; arvalid = 1'b0; end
      if (hs_r) r_done = 1;
    end
    arvalid = 1'b0; rready = 1'b0;
    check($sformatf("rd_done@%02h", addr), r_done, 1'b1);
    if (r_done) check($sformatf("rresp@%02h", addr), resp, 2'b00);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, output int upd);
    axi_write(a, d, 4'hF, 0, 0, 1'b0, upd);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int s;
    axi_read(a, d, s);
    check(name, d, exp);
  endtask

  task automatic chk_outputs_zero(input string tag);
    check({tag, "_awready"}, awready, 1'b0);
    check({tag, "_wready"},  wready,  1'b0);
    check({tag, "_bvalid"},  bvalid,  1'b0);
    check({tag, "_arready"}, arready, 1'b0);
    check({tag, "_rvalid"},  rvalid,  1'b0);
    check({tag, "_rdata"},   rdata,   32'h0);
    check({tag, "_bresp"},   bresp,   2'b00);
    check({tag, "_rresp"},   rresp,   2'b00);
    check({tag, "_irq"},     irq,     1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, stop, u, s, l, gap;
    bit ar;
    logic [31:0] d;
    logic [4:0] a;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // Register map vectors
    tbl.push_back('{1'b1, 5'h00, 32'h0000_0006, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 5'h04, 32'h0000_0002, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 5'h08, 32'h0000_0003, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 5'h0C, 32'h0000_0004, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_0006});
    tbl.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'h0000_0002});
    tbl.push_back('{1'b0, 5'h08, 32'h0, 4'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 5'h0C, 32'h0, 4'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 5'h04, 32'hAABB_CCDD, 4'h5, 32'h0});
    tbl.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'h00BB_00DD});
    tbl.push_back('{1'b1, 5'h00, 32'hFFFF_FFF8, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 5'h14, 32'hDEAD_BEEF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 5'h14, 32'h0, 4'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 5'h1C, 32'h0, 4'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 5'h10, 32'h0, 4'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 5'h10, 32'h0001_2345, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 5'h10, 32'h0, 4'h0, EXP_PSC});
    tbl.push_back('{1'b1, 5'h10, 32'h0000_0000, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 5'h04, 32'h0, 4'h0, 32'h00BB_00DD});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, 1'b0, u);
        $display("vec %0d: write 0x%02h <= 0x%08h strb %h", i, tbl[i].addr, tbl[i].data, tbl[i].strb);
      end else begin
        axi_read(tbl[i].addr, d, s);
        check($sformatf("tbl%0d_rd@%02h", i, tbl[i].addr), d, tbl[i].exp);
        $display("vec %0d: read 0x%02h -> 0x%08h (want 0x%08h)", i, tbl[i].addr, d, tbl[i].exp);
      end
    end

    // One-shot with interrupt: cycle-exact irq timing
    wr(5'h04, 32'd5, u);
    wr(5'h00, 32'h5, st);
    while (cyc - st <= 10) begin
      check($sformatf("oneshot_irq_k%0d", cyc - st), irq, (cyc - st) >= 7);
      tick();
    end
    rd_chk("oneshot_ctrl", 5'h00, 32'h4);
    rd_chk("oneshot_status", 5'h0C, 32'h1);
    rd_chk("oneshot_count", 5'h08, 32'h0);
    wr(5'h0C, 32'h1, u);
    tick();
    check("w1c_irq_low", irq, 1'b0);
    rd_chk("w1c_status", 5'h0C, 32'h0);
    wr(5'h00, 32'h0, u);
    $display("seq oneshot_irq done");

    // One-shot without interrupt: live COUNT reads
    wr(5'h00, 32'h1, st);
    while (cyc - st <= 9) begin
      axi_read(5'h08, d, s);
      check($sformatf("os_count_k%0d", s - st), d, mdl_count(s - st, 5, 1'b0));
    end
    rd_chk("os_status", 5'h0C, 32'h1);
    rd_chk("os_ctrl", 5'h00, 32'h0);
    check("os_irq_masked", irq, 1'b0);
    wr(5'h0C, 32'h1, u);
    $display("seq oneshot_count done");

    // Auto-reload LOAD=2
    wr(5'h04, 32'd2, u);
    wr(5'h00, 32'h3, st);
    repeat (7) begin
      axi_read(5'h08, d, s);
      check($sformatf("ar_count_k%0d", s - st), d, mdl_count(s - st, 2, 1'b1));
    end
    rd_chk("ar_status", 5'h0C, 32'h1);
    wr(5'h00, 32'h0, stop);
    axi_read(5'h08, d, s);
    check("ar_hold", d, mdl_count(stop - 1 - st, 2, 1'b1));
    wr(5'h0C, 32'h1, u);
    $display("seq auto_reload done");

    // W1C racing a hardware set: LOAD=0 auto-reload expires every tick
    wr(5'h04, 32'd0, u);
    wr(5'h00, 32'h3, st);
    tick();
    wr(5'h0C, 32'h1, u);
    rd_chk("race_status", 5'h0C, 32'h1);
    wr(5'h00, 32'h0, u);
    wr(5'h0C, 32'h1, u);
    rd_chk("race_cleared", 5'h0C, 32'h0);
    $display("seq w1c_race done");

    // AW 3 cycles ahead of W, bready held low 4 cycles, AW kept asserted
    axi_write(5'h04, 32'h1234_5678, 4'hF, 3, 4, 1'b1, u);
    rd_chk("lag_load", 5'h04, 32'h1234_5678);
    rd_chk("lag_unmapped", 5'h1C, 32'h0);
    $display("seq aw_lead_b_stall done");

`ifdef AXI_TIMER_PRESCALE_EN
    // PRESCALE=3, LOAD=1: expiry 8 cycles after start, irq one later
    wr(5'h10, 32'd3, u);
    wr(5'h04, 32'd1, u);
    wr(5'h00, 32'h5, st);
    while (cyc - st <= 12) begin
      check($sformatf("psc_irq_k%0d", cyc - st), irq, (cyc - st) >= 9);
      tick();
    end
    wr(5'h00, 32'h0, u);
    wr(5'h0C, 32'h1, u);
    wr(5'h10, 32'h0, u);
    $display("seq prescale done");
`endif

    // Randomized runs against the closed-form model
    for (int it = 0; it < 8; it++) begin
      l  = $urandom_range(0, 6);
      ar = 1'($urandom_range(0, 1));
      wr(5'h00, 32'h0, u);
      wr(5'h0C, 32'h1, u);
      wr(5'h04, l, u);
      wr(5'h00, {30'd0, ar, 1'b1}, st);
      repeat (5) begin
        gap = $urandom_range(0, 3);
        repeat (gap) tick();
        case ($urandom_range(0, 2))
          0: a = 5'h00;
          1: a = 5'h08;
          default: a = 5'h0C;
        endcase
        axi_read(a, d, s);
        if (a == 5'h00)
          check($sformatf("rnd%0d_ctrl_k%0d", it, s - st), d, {30'd0, ar, mdl_en(s - st, l, ar)});
        else if (a == 5'h08)
          check($sformatf("rnd%0d_count_k%0d", it, s - st), d, mdl_count(s - st, l, ar));
        else
          check($sformatf("rnd%0d_status_k%0d", it, s - st), d, {31'd0, mdl_expired(s - st, l)});
      end
      wr(5'h00, 32'h0, stop);
      repeat ($urandom_range(0, 3)) tick();
      axi_read(5'h08, d, s);
      check($sformatf("rnd%0d_hold", it), d, mdl_count(stop - 1 - st, l, ar));
      $display("rnd %0d: load %0d auto %0d stopped at k%0d count 0x%08h", it, l, ar, stop - st, d);
    end

    // Reset in the middle of a running timer and pending AXI requests
    wr(5'h04, 32'd9, u);
    wr(5'h00, 32'h5, u);
    awaddr = 5'h04; awvalid = 1'b1;
    araddr = 5'h04; arvalid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_outputs_zero("midrst");
    awvalid = 1'b0; arvalid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rd_chk("midrst_ctrl", 5'h00, 32'h0);
    rd_chk("midrst_load", 5'h04, 32'h0);
    rd_chk("midrst_count", 5'h08, 32'h0);
    rd_chk("midrst_status", 5'h0C, 32'h0);
    $display("seq mid_reset done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
